// File: rtl/keypad_pkg.sv
// Shared types and sizing helpers for the keypad row scanner.
package keypad_pkg;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned ROW_W = 3;

  typedef enum logic [1:0] {
    ST_SCAN         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_REPORT       = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } scan_state_t;

  // Column-index width; never narrower than one bit.
  function automatic int unsigned cw_of(input int unsigned cols);
    return (cols > 2) ? $clog2(cols) : 1;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Row-dwell prescaler: counts 0..DIV-1 and flags the last cycle of each dwell.
module scan_prescaler #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0] r_count;
  logic             r_tick;

  // tick is registered one cycle ahead so it is high exactly while count == DIV-1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_count <= (r_count == DIV_W'(DIV - 1)) ? '0 : r_count + DIV_W'(1);
      r_tick  <= (r_count == DIV_W'(DIV - 2));
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/keypad_row_scanner.sv
// 8-row key matrix scanner: row sequencing, press/release debounce and
// one {row, col} event per press over a valid/ready handshake.
module keypad_row_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned COLS     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic [ROW_W-1:0]                row_sel,
  input  logic [COLS-1:0]                 col_in,
  output logic                            key_valid,
  input  logic                            key_ready,
  output logic [ROW_W+cw_of(COLS)-1:0]    key_code
);

  localparam int unsigned CW   = cw_of(COLS);
  localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);

  scan_state_t       r_state,     w_state_nxt;
  logic [ROW_W-1:0]  r_row_sel,   w_row_nxt;
  logic [CW-1:0]     r_col,       w_col_nxt;
  logic [ROW_W+CW-1:0] r_key_code, w_code_nxt;
  logic              r_key_valid, w_valid_nxt;
  logic [DB_W-1:0]   r_press_cnt, w_press_nxt;
  logic [DB_W-1:0]   r_rel_cnt,   w_rel_nxt;
  logic [CW-1:0]     w_first_col;
  logic              w_col_bit;
  logic              w_tick;

  scan_prescaler #(
    .DIV (SCAN_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_col_bit = |(col_in & (COLS'(1) << r_col));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SCAN;
      r_row_sel   <= '0;
      r_col       <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_press_cnt <= '0;
      r_rel_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_row_sel   <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_key_code  <= w_code_nxt;
      r_key_valid <= w_valid_nxt;
      r_press_cnt <= w_press_nxt;
      r_rel_cnt   <= w_rel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row_sel;
    w_col_nxt   = r_col;
    w_code_nxt  = r_key_code;
    w_press_nxt = r_press_cnt;
    w_rel_nxt   = r_rel_cnt;
    w_first_col = '0;

    // descending walk so the lowest set column wins
    for (int i = int'(COLS) - 1; i >= 0; i--) begin
      if (col_in[i]) w_first_col = CW'(i);
    end

    case (r_state)
      ST_SCAN: begin
        if (w_tick) begin
          if (|col_in) begin
            w_col_nxt   = w_first_col;
            w_code_nxt  = {r_row_sel, w_first_col};
            w_press_nxt = DB_W'(1);
            w_state_nxt = (DEBOUNCE == 1) ? ST_REPORT : ST_DEBOUNCE;
          end else begin
            w_row_nxt = r_row_sel + ROW_W'(1);
          end
        end
      end
      ST_DEBOUNCE: begin
        if (w_tick) begin
          if (w_col_bit) begin
            w_press_nxt = r_press_cnt + DB_W'(1);
            if (w_press_nxt == DB_W'(DEBOUNCE)) w_state_nxt = ST_REPORT;
          end else begin
            w_press_nxt = '0;
            w_row_nxt   = r_row_sel + ROW_W'(1);
            w_state_nxt = ST_SCAN;
          end
        end
      end
      ST_REPORT: begin
        if (r_key_valid && key_ready) begin
          w_rel_nxt   = '0;
          w_state_nxt = ST_WAIT_RELEASE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (w_tick) begin
          if (!w_col_bit) begin
            w_rel_nxt = r_rel_cnt + DB_W'(1);
            if (w_rel_nxt == DB_W'(DEBOUNCE)) begin
              w_rel_nxt   = '0;
              w_row_nxt   = r_row_sel + ROW_W'(1);
              w_state_nxt = ST_SCAN;
            end
          end else begin
            w_rel_nxt = '0;
          end
        end
      end
      default: w_state_nxt = ST_SCAN;
    endcase

    w_valid_nxt = (w_state_nxt == ST_REPORT);
  end

  assign row_sel   = r_row_sel;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;

endmodule

// File: doc/keypad_row_scanner.md
# keypad_row_scanner

Sequential scan controller for an 8-row × COLS-column key matrix. It generates the 3-bit row-select code that drives the downstream `decoder3to8`, which produces the one-hot row strobe. The block samples the column return lines, debounces presses and releases, and delivers one encoded key event per press over a valid/ready handshake.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles per row dwell; legal range ≥ 2.
- DEBOUNCE, 4: consecutive matching samples required to confirm a press or a release; legal range ≥ 1.
- COLS, 4: number of column inputs; legal range 1..8.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- row_sel  out  3  row code, connected to `decoder3to8` x.
- col_in  in  COLS  column returns, active-high, already synchronised upstream.
- key_valid  out  1  key event available.
- key_ready  in  1  consumer accepts the event.
- key_code  out  3+CW  {row, col}, where CW = max(1, clog2(COLS)).

## Operation
- Prescaler counts 0..SCAN_DIV-1 and wraps. A tick occurs in the cycle where count == SCAN_DIV-1. col_in is sampled only on a tick, at the end of a row dwell, so it has had time to settle.
- **SCAN**
  - Sample on each tick.
  - Sample zero: row_sel increments on the same edge (7 wraps to 0).
  - Sample non-zero: latch row_sel and the lowest set column index, set debounce count to 1, go to DEBOUNCE. row_sel holds.
- **DEBOUNCE** (row_sel held)
  - On each tick, if the latched column bit is still set, increment the count.
  - When the count reaches DEBOUNCE, go to REPORT.
  - If the bit is clear, go to SCAN and advance row_sel.
  - With DEBOUNCE = 1, the detecting sample goes directly to REPORT.
- **REPORT**
  - key_valid = 1. key_code is stable until transfer.
  - Transfer occurs when key_valid & key_ready are both high on a clock edge. Then go to WAIT_RELEASE with the release count at 0.
  - Prescaler keeps running; col_in is ignored.
  - A release during REPORT does not cancel the event.
- **WAIT_RELEASE** (row_sel held)
  - On each tick, if the latched column bit is clear, increment the release count; otherwise reset it to 0.
  - When the count reaches DEBOUNCE, go to SCAN and advance row_sel.
- **Multiple keys**
  - Within a row, the lowest column index wins.
  - Across rows, scan order decides.
  - Other keys held during WAIT_RELEASE are ignored until their rows are scanned again.
- **Reset values:** row_sel = 0, key_valid = 0, key_code = 0, prescaler = 0, state = SCAN, both counters = 0.

## Timing
- After reset deassert, the first tick is at cycle SCAN_DIV-1 (cycle 0 is the first edge with rst low).
- key_valid rises on the edge following the DEBOUNCE-th confirming tick.
  - Detect-to-valid latency is (DEBOUNCE-1)·SCAN_DIV + 1 cycles.
- key_ready may be high before key_valid. In that case the transfer happens in the first cycle key_valid is high, so key_valid is high for exactly 1 cycle.
- key_valid falls on the edge after the transfer.
- rst asserted mid-operation overrides everything on the next edge:
  - A pending event is dropped.
  - key_valid is low the following cycle.
- row_sel changes only on tick edges and is registered (glitch-free into the decoder).

## Structure
- Package `keypad_pkg` holds:
  - the state enum SCAN / DEBOUNCE / REPORT / WAIT_RELEASE (2-bit encoding);
  - ROWS = 8 and ROW_W = 3;
  - a function computing CW from COLS.
- Sub-module `scan_prescaler` (parameter DIV; ports clk, rst, tick) generates the dwell tick.
- The FSM, counters and column select live in `keypad_row_scanner`.
- `decoder3to8` is instantiated by the parent, not inside this block.

## Test plan
All scenarios use SCAN_DIV = 4, DEBOUNCE = 2, COLS = 4, key_ready = 1 unless stated.
- **Idle scan:** reset, col_in = 0. row_sel = 0 during cycles 0–3, 1 during 4–7, … 7 during 28–31, then wraps to 0 at cycle 32. key_valid never rises.
- **Single press:** col_in[1] high whenever row_sel = 2, held.
  - Detect at cycle 11, confirm at cycle 15.
  - key_valid is high at cycle 16 only, with key_code = 5'b010_01.
  - No second event until col_in[1] has been low for 2 ticks.
- **Bounce reject:** col_in[1] high only at the row-2 tick (cycle 11), low after. State returns to SCAN, row_sel = 3 at cycle 16, no event.
- **Backpressure:** single press with key_ready low until cycle 40.
  - key_valid is held from cycle 16 with code 9 stable.
  - Transfer at cycle 40, key_valid low at cycle 41.
- **Priority:** col_in = 4'b1010 on row 5 yields key_code = {3'd5, 2'd1}.
- **Reset mid-REPORT:** with key_valid high and key_ready low, pulse rst for 1 cycle. Next cycle key_valid = 0, row_sel = 0, and the scan restarts from row 0.
